// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: walks the loop through reset release, high-gain acquisition,
// tracking and lock, with loss-of-lock detection and a timed brake/frequency-hop phase.
module pll_lock_sequencer #(
  parameter int ERR_W        = 16,
  parameter int RESET_CYCLES = 4,
  parameter int ACQ_CYCLES   = 64,
  parameter int LOCK_TOL     = 2,
  parameter int LOCK_COUNT   = 32,
  parameter int UNLOCK_TOL   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int BRAKE_CYCLES = 100
) (
  input  logic                    refclk,
  input  logic                    reset,
  input  logic                    en,
  input  logic signed [ERR_W-1:0] err,
  input  logic                    brake_req,
  output logic                    pll_resetn,
  output logic                    gain_hi,
  output logic                    brake,
  output logic                    locked,
  output logic                    lock_lost,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_BRAKE   = 3'd5
  } state_t;

  // One shared phase timer serves RELEASE, ACQUIRE and BRAKE.
  localparam int PHASE_MAX_A = (RESET_CYCLES > ACQ_CYCLES) ? RESET_CYCLES : ACQ_CYCLES;
  localparam int PHASE_MAX   = (PHASE_MAX_A > BRAKE_CYCLES) ? PHASE_MAX_A : BRAKE_CYCLES;
  localparam int PHASE_W     = $clog2(PHASE_MAX + 1);
  localparam int LOCK_W      = $clog2(LOCK_COUNT + 1);
  localparam int UNLOCK_W    = $clog2(UNLOCK_COUNT + 1);

  localparam logic [PHASE_W-1:0]  RESET_LAST  = PHASE_W'(RESET_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  ACQ_LAST    = PHASE_W'(ACQ_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  BRAKE_LAST  = PHASE_W'(BRAKE_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  PHASE_TOP   = PHASE_W'(PHASE_MAX - 1);
  localparam logic [PHASE_W-1:0]  PHASE_ONE   = PHASE_W'(1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_COUNT - 1);
  localparam logic [LOCK_W-1:0]   LOCK_ONE    = LOCK_W'(1);
  localparam logic [UNLOCK_W-1:0] UNLOCK_LAST = UNLOCK_W'(UNLOCK_COUNT - 1);
  localparam logic [UNLOCK_W-1:0] UNLOCK_ONE  = UNLOCK_W'(1);

  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MOST_NEG = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-2:0] MAG_MAX     = '1;
  localparam logic [ERR_W-2:0] LOCK_TOL_V  = (ERR_W-1)'(LOCK_TOL);
  localparam logic [ERR_W-2:0] UNLOCK_TOL_V = (ERR_W-1)'(UNLOCK_TOL);

  state_t                state_reg, state_next;
  logic [PHASE_W-1:0]    phase_cnt_reg, phase_cnt_next, phase_cnt_inc;
  logic [LOCK_W-1:0]     lock_cnt_reg, lock_cnt_next, lock_cnt_inc;
  logic [UNLOCK_W-1:0]   unlock_cnt_reg, unlock_cnt_next, unlock_cnt_inc;
  logic                  pll_resetn_reg, pll_resetn_next;
  logic                  gain_hi_reg, gain_hi_next;
  logic                  brake_reg, brake_next;
  logic                  locked_reg, locked_next;
  logic                  lock_lost_reg, lock_lost_next;

  logic [ERR_W-1:0]      err_neg;
  logic [ERR_W-2:0]      err_mag;
  logic                  in_lock;
  logic                  out_lock;

  // |err| with the most-negative code clamped to the largest positive magnitude.
  always_comb begin
    err_neg = ~err + ERR_ONE;
    if (!err[ERR_W-1])
      err_mag = err[ERR_W-2:0];
    else if (err == ERR_MOST_NEG)
      err_mag = MAG_MAX;
    else
      err_mag = err_neg[ERR_W-2:0];
  end

  assign in_lock  = (err_mag <= LOCK_TOL_V);
  assign out_lock = (err_mag > UNLOCK_TOL_V);

  assign phase_cnt_inc  = (phase_cnt_reg == PHASE_TOP) ? phase_cnt_reg : phase_cnt_reg + PHASE_ONE;
  assign lock_cnt_inc   = (lock_cnt_reg == LOCK_LAST) ? lock_cnt_reg : lock_cnt_reg + LOCK_ONE;
  assign unlock_cnt_inc = (unlock_cnt_reg == UNLOCK_LAST) ? unlock_cnt_reg : unlock_cnt_reg + UNLOCK_ONE;

  always_comb begin
    state_next      = state_reg;
    phase_cnt_next  = phase_cnt_reg;
    lock_cnt_next   = lock_cnt_reg;
    unlock_cnt_next = unlock_cnt_reg;
    lock_lost_next  = lock_lost_reg;
    brake_next      = 1'b0;

    if (!en) begin
      state_next      = ST_IDLE;
      phase_cnt_next  = '0;
      lock_cnt_next   = '0;
      unlock_cnt_next = '0;
      lock_lost_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next     = ST_RELEASE;
          phase_cnt_next = '0;
        end
        ST_RELEASE: begin
          if (phase_cnt_reg == RESET_LAST) begin
            state_next     = ST_ACQUIRE;
            phase_cnt_next = '0;
          end else begin
            phase_cnt_next = phase_cnt_inc;
          end
        end
        ST_ACQUIRE: begin
          if (phase_cnt_reg == ACQ_LAST) begin
            state_next     = ST_TRACK;
            phase_cnt_next = '0;
            lock_cnt_next  = '0;
          end else begin
            phase_cnt_next = phase_cnt_inc;
          end
        end
        ST_TRACK: begin
          if (brake_req) begin
            state_next     = ST_BRAKE;
            phase_cnt_next = '0;
            lock_cnt_next  = '0;
            brake_next     = 1'b1;
          end else if (in_lock) begin
            if (lock_cnt_reg == LOCK_LAST) begin
              state_next      = ST_LOCKED;
              lock_cnt_next   = '0;
              unlock_cnt_next = '0;
            end else begin
              lock_cnt_next = lock_cnt_inc;
            end
          end else begin
            lock_cnt_next = '0;
          end
        end
        ST_LOCKED: begin
          // A brake request outranks a simultaneous loss of lock.
          if (brake_req) begin
            state_next      = ST_BRAKE;
            phase_cnt_next  = '0;
            unlock_cnt_next = '0;
            brake_next      = 1'b1;
          end else if (out_lock) begin
            if (unlock_cnt_reg == UNLOCK_LAST) begin
              state_next      = ST_ACQUIRE;
              phase_cnt_next  = '0;
              unlock_cnt_next = '0;
              lock_lost_next  = 1'b1;
            end else begin
              unlock_cnt_next = unlock_cnt_inc;
            end
          end else begin
            unlock_cnt_next = '0;
          end
        end
        ST_BRAKE: begin
          if (phase_cnt_reg == BRAKE_LAST) begin
            state_next     = ST_TRACK;
            phase_cnt_next = '0;
            lock_cnt_next  = '0;
          end else begin
            phase_cnt_next = phase_cnt_inc;
          end
        end
        default: begin
          state_next      = ST_IDLE;
          phase_cnt_next  = '0;
          lock_cnt_next   = '0;
          unlock_cnt_next = '0;
          lock_lost_next  = 1'b0;
        end
      endcase
    end

    pll_resetn_next = (state_next != ST_IDLE) && (state_next != ST_RELEASE);
    gain_hi_next    = (state_next == ST_ACQUIRE);
    locked_next     = (state_next == ST_LOCKED);
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      phase_cnt_reg  <= '0;
      lock_cnt_reg   <= '0;
      unlock_cnt_reg <= '0;
      pll_resetn_reg <= 1'b0;
      gain_hi_reg    <= 1'b0;
      brake_reg      <= 1'b0;
      locked_reg     <= 1'b0;
      lock_lost_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_cnt_reg  <= phase_cnt_next;
      lock_cnt_reg   <= lock_cnt_next;
      unlock_cnt_reg <= unlock_cnt_next;
      pll_resetn_reg <= pll_resetn_next;
      gain_hi_reg    <= gain_hi_next;
      brake_reg      <= brake_next;
      locked_reg     <= locked_next;
      lock_lost_reg  <= lock_lost_next;
    end
  end

  assign pll_resetn = pll_resetn_reg;
  assign gain_hi    = gain_hi_reg;
  assign brake      = brake_reg;
  assign locked     = locked_reg;
  assign lock_lost  = lock_lost_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus randomized err/brake_req/en
// traffic checked cycle by cycle against an elapsed-time/streak reference model.
module tb_pll_lock_sequencer;

  localparam int ERR_W        = 16;
  localparam int RESET_CYCLES = 4;
  localparam int ACQ_CYCLES   = 64;
  localparam int LOCK_TOL     = 2;
  localparam int LOCK_COUNT   = 32;
  localparam int UNLOCK_TOL   = 8;
  localparam int UNLOCK_COUNT = 4;
  localparam int BRAKE_CYCLES = 100;

  logic                    refclk = 1'b0;
  logic                    reset;
  logic                    en;
  logic signed [ERR_W-1:0] err;
  logic                    brake_req;
  logic                    pll_resetn, gain_hi, brake, locked, lock_lost;
  logic [2:0]              state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, cycles spent in the phase, good/bad streak lengths.
  int m_state, m_age, m_good, m_bad;
  bit m_brake, m_lost;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .ERR_W(ERR_W), .RESET_CYCLES(RESET_CYCLES), .ACQ_CYCLES(ACQ_CYCLES),
    .LOCK_TOL(LOCK_TOL), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_TOL(UNLOCK_TOL),
    .UNLOCK_COUNT(UNLOCK_COUNT), .BRAKE_CYCLES(BRAKE_CYCLES)
  ) dut (
    .refclk(refclk), .reset(reset), .en(en), .err(err), .brake_req(brake_req),
    .pll_resetn(pll_resetn), .gain_hi(gain_hi), .brake(brake), .locked(locked),
    .lock_lost(lock_lost), .state(state)
  );

  function automatic int mag_of(int e);
    int m;
    m = (e < 0) ? -e : e;
    return (m > 32767) ? 32767 : m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_age = 0; m_good = 0; m_bad = 0; m_brake = 0; m_lost = 0;
  endtask

  task automatic model_step();
    int mag;
    mag = mag_of(int'(err));
    m_brake = 0;
    if (!en) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin m_state = 1; m_age = 0; end
      1: begin m_age++; if (m_age == RESET_CYCLES) begin m_state = 2; m_age = 0; end end
      2: begin m_age++; if (m_age == ACQ_CYCLES) begin m_state = 3; m_age = 0; m_good = 0; end end
      3: begin
        if (brake_req) begin m_state = 5; m_age = 0; m_brake = 1; end
        else if (mag <= LOCK_TOL) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin m_state = 4; m_bad = 0; end
        end else m_good = 0;
      end
      4: begin
        if (brake_req) begin m_state = 5; m_age = 0; m_brake = 1; end
        else if (mag > UNLOCK_TOL) begin
          m_bad++;
          if (m_bad == UNLOCK_COUNT) begin m_state = 2; m_age = 0; m_lost = 1; end
        end else m_bad = 0;
      end
      5: begin m_age++; if (m_age == BRAKE_CYCLES) begin m_state = 3; m_age = 0; m_good = 0; end end
      default: model_reset();
    endcase
  endtask

  function automatic logic [7:0] model_vec();
    return {3'(m_state), (m_state >= 2), (m_state == 2), m_brake, (m_state == 4), m_lost};
  endfunction

  // Advance one edge; inputs were set just after the previous edge.
  task automatic tick();
    @(posedge refclk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic go_locked();
    en = 1'b0; brake_req = 1'b0; err = '0;
    tick();
    en = 1'b1;
    repeat (101) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; err = 16'sd1000; brake_req = 1'b1;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({state, pll_resetn, gain_hi, brake, locked, lock_lost} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", {state, pll_resetn, gain_hi, brake, locked, lock_lost}, 8'h00);
    end
    reset = 1'b0; en = 1'b0; brake_req = 1'b0; err = '0;
    tick();
    checks++;
    if ({state, pll_resetn} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got state=%0d resetn=%b required state=0 resetn=0", state, pll_resetn);
    end
    $display("test_reset: state=%0d", state);
  endtask

  task automatic test_lock_sequence();
    logic [2:0] exp_v;
    en = 1'b1; err = '0;
    for (int k = 1; k <= 101; k++) begin
      tick();
      exp_v = {(k >= 5), (k >= 5 && k <= 68), (k >= 101)};
      checks++;
      if ({pll_resetn, gain_hi, locked} !== exp_v) begin
        errors++;
        $display("FAIL lock_seq edge %0d: got resetn/gain/locked=%b required %b", k, {pll_resetn, gain_hi, locked}, exp_v);
      end
    end
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL lock_seq_state: got %0d required 4", state);
    end
    $display("test_lock_sequence: locked=%b state=%0d", locked, state);
  endtask

  task automatic test_lock_restart();
    en = 1'b0; err = '0; tick();
    en = 1'b1; repeat (69) tick();
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL track_entry: got state %0d required 3", state);
    end
    repeat (20) tick();
    err = 16'sd3; tick();
    err = '0;
    repeat (31) tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL restart_early: got locked %b required 0 at 31 edges after glitch", locked);
    end
    tick();
    checks++;
    if ({state, locked} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL restart_lock: got state %0d locked %b required 4 1", state, locked);
    end
    $display("test_lock_restart: locked=%b", locked);
  endtask

  task automatic test_unlock();
    err = 16'sd9;
    repeat (3) tick();
    err = '0; tick();
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL unlock_first_burst: got state %0d required 4", state);
    end
    err = -16'sd9;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (k < 4 && state !== 3'd4) begin
        errors++;
        $display("FAIL unlock_burst edge %0d: got state %0d required 4", k, state);
      end else if (k == 4 && {state, locked, lock_lost, gain_hi} !== {3'd2, 1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL unlock_declare: got state %0d locked %b lost %b gain %b required 2 0 1 1", state, locked, lock_lost, gain_hi);
      end
    end
    err = '0;
    $display("test_unlock: state=%0d lock_lost=%b", state, lock_lost);
  endtask

  task automatic test_brake();
    go_locked();
    checks++;
    if ({state, lock_lost} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL brake_setup: got state %0d lost %b required 4 0", state, lock_lost);
    end
    brake_req = 1'b1; tick(); brake_req = 1'b0;
    checks++;
    if ({state, brake, locked, gain_hi} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL brake_entry: got state %0d brake %b locked %b gain %b required 5 1 0 0", state, brake, locked, gain_hi);
    end
    for (int k = 2; k <= 101; k++) begin
      tick();
      checks++;
      if ({state, brake} !== {((k <= 100) ? 3'd5 : 3'd3), 1'b0}) begin
        errors++;
        $display("FAIL brake_hold edge %0d: got state %0d brake %b", k, state, brake);
      end
    end
    // Brake and unlock threshold on the same edge.
    go_locked();
    err = 16'sd9; repeat (3) tick();
    brake_req = 1'b1; tick(); brake_req = 1'b0; err = '0;
    checks++;
    if ({state, brake, lock_lost} !== {3'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL brake_priority: got state %0d brake %b lost %b required 5 1 0", state, brake, lock_lost);
    end
    en = 1'b0; tick(); en = 1'b1; repeat (5) tick();
    brake_req = 1'b1; tick(); brake_req = 1'b0;
    checks++;
    if ({state, brake} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL brake_in_acquire: got state %0d brake %b required 2 0", state, brake);
    end
    $display("test_brake: state=%0d", state);
  endtask

  task automatic test_saturation();
    go_locked();
    err = -16'sd32768;
    repeat (3) tick();
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL sat_hold: got state %0d required 4", state);
    end
    tick();
    checks++;
    if ({state, locked, lock_lost} !== {3'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_unlock: got state %0d locked %b lost %b required 2 0 1", state, locked, lock_lost);
    end
    err = '0;
    $display("test_saturation: state=%0d", state);
  endtask

  task automatic test_en_drop_and_reset();
    go_locked();
    brake_req = 1'b1; tick(); brake_req = 1'b0;
    repeat (10) tick();
    en = 1'b0; tick();
    checks++;
    if ({state, pll_resetn, gain_hi, brake, locked, lock_lost} !== 8'h00) begin
      errors++;
      $display("FAIL en_drop: got %b required %b", {state, pll_resetn, gain_hi, brake, locked, lock_lost}, 8'h00);
    end
    en = 1'b1; repeat (6) tick();
    checks++;
    if ({state, gain_hi} !== {3'd2, 1'b1}) begin
      errors++;
      $display("FAIL reacquire: got state %0d gain %b required 2 1", state, gain_hi);
    end
    #2 reset = 1'b1; model_reset();
    #1;
    checks++;
    if ({state, pll_resetn, gain_hi} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset: got state %0d resetn %b gain %b required 0 0 0", state, pll_resetn, gain_hi);
    end
    tick(); reset = 1'b0;
    go_locked();
    brake_req = 1'b1; tick(); brake_req = 1'b0;
    #2 reset = 1'b1; model_reset();
    #1;
    checks++;
    if ({state, brake, pll_resetn} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_in_pulse: got state %0d brake %b resetn %b required 0 0 0", state, brake, pll_resetn);
    end
    tick(); reset = 1'b0;
    $display("test_en_drop_and_reset: state=%0d", state);
  endtask

  task automatic test_random();
    int len, mode, seg_err;
    logic [7:0] got_v, exp_v;
    en = 1'b0; brake_req = 1'b0; err = '0; tick();
    en = 1'b1;
    for (int seg = 0; seg < 150; seg++) begin
      len = $urandom_range(60, 1);
      mode = $urandom_range(9, 0);
      en = ($urandom_range(24, 0) != 0);
      seg_err = 0;
      for (int c = 0; c < len; c++) begin
        if (mode <= 5)      err = 16'(int'($urandom_range(4, 0)) - 2);
        else if (mode <= 7) err = 16'(int'($urandom_range(24, 0)) - 12);
        else if (mode == 8) err = 16'($urandom);
        else                err = ($urandom_range(1, 0) != 0) ? -16'sd32768 : 16'sd32767;
        brake_req = ($urandom_range(149, 0) == 0);
        tick();
        got_v = {state, pll_resetn, gain_hi, brake, locked, lock_lost};
        exp_v = model_vec();
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          seg_err++;
          $display("FAIL random seg %0d cycle %0d: got state/resetn/gain/brake/locked/lost=%b required %b", seg, c, got_v, exp_v);
        end
      end
      $display("random seg %0d: mode %0d len %0d en %b state %0d mismatches %0d", seg, mode, len, en, state, seg_err);
    end
    brake_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; err = '0; brake_req = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_lock_sequence();
    test_lock_restart();
    test_unlock();
    test_brake();
    test_saturation();
    test_en_drop_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
